// File: rtl/balu_ctrl.sv
// balu_ctrl: valid/ready sequencer decoding Zbb/Zbs ops into BALU mode codes, with an iterative CPOP engine.
// Optional: define BALU_CTRL_CPOP_EN to decode CPOP and build the popcount engine; otherwise CPOP is illegal.
module balu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] balu_num1,
  output logic [31:0] balu_num2,
  output logic [7:0]  balu_mode,
  input  logic [31:0] balu_ans,
  input  logic        balu_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, CPOP, DONE} state_t;
  state_t state, state_nx;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] sh;
  logic is_op, is_imm, dec_cpop, dec_ill, cpop_last;
  logic [7:0] dec_mode;
  logic [31:0] cpop_res;
  assign opcode = instr[6:0];
  assign f3 = instr[14:12];
  assign sh = instr[24:20];
  assign f7 = instr[31:25];
  assign is_op = opcode == 7'b0110011;
  assign is_imm = opcode == 7'b0010011;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  always_comb begin
    dec_mode = 8'h00;
    if (is_op || is_imm)
      case ({f3, f7})
        {3'b001, 7'b0100100}: dec_mode = 8'h30;
        {3'b001, 7'b0110100}: dec_mode = 8'h32;
        {3'b001, 7'b0010100}: dec_mode = 8'h33;
        {3'b101, 7'b0100100}: dec_mode = 8'h31;
        {3'b101, 7'b0110000}: dec_mode = 8'h38;
        {3'b001, 7'b0110000}: dec_mode = is_op ? 8'h37 : sh == 5'd0 ? 8'h34 : sh == 5'd1 ? 8'h36 : 8'h00;
        default: dec_mode = 8'h00;
      endcase
  end
  assign dec_ill = dec_mode == 8'h00 && !dec_cpop;
`ifdef BALU_CTRL_CPOP_EN
  logic [31:0] shift;
  logic [5:0] acc, acc_nx;
  logic [2:0] beat;
  assign dec_cpop = is_imm && f3 == 3'b001 && f7 == 7'b0110000 && sh == 5'd2;
  assign acc_nx = acc + 6'(shift[0]) + 6'(shift[1]) + 6'(shift[2]) + 6'(shift[3]);
  assign cpop_last = beat == 3'd7;
  assign cpop_res = {26'b0, acc_nx};
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      acc <= '0;
      beat <= '0;
    end else if (state == IDLE && in_valid) begin
      shift <= rs1_data;
      acc <= '0;
      beat <= '0;
    end else if (state == CPOP) begin
      shift <= shift >> 4;
      acc <= acc_nx;
      beat <= beat + 3'd1;
    end
  end
`else
  assign dec_cpop = 1'b0;
  assign cpop_last = 1'b1;
  assign cpop_res = '0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = dec_ill ? DONE : dec_cpop ? CPOP : EXEC;
      EXEC: state_nx = DONE;
      CPOP: if (cpop_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      balu_mode <= '0;
      balu_num1 <= '0;
      balu_num2 <= '0;
      out_data <= '0;
      out_illegal <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          out_illegal <= dec_ill;
          if (dec_ill) out_data <= '0;
          if (!dec_ill && !dec_cpop) begin
            balu_mode <= dec_mode;
            balu_num1 <= rs1_data;
            balu_num2 <= is_imm ? {27'b0, sh} : rs2_data;
          end
        end
        EXEC: begin
          out_data <= balu_ans;
          out_illegal <= balu_error;
        end
        CPOP: if (cpop_last) out_data <= cpop_res;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_balu_ctrl.sv
// tb_balu_ctrl: directed self-checking bench for balu_ctrl with a behavioural BALU stub.
module tb_balu_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, force_err = 0;
  logic in_ready, out_valid, out_illegal, balu_error, model_err;
  logic [31:0] instr = 0, rs1_data = 0, rs2_data = 0, balu_num1, balu_num2, balu_ans, out_data;
  logic [7:0] balu_mode;
  int checks = 0, failures = 0;
  localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011;

  balu_ctrl dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .balu_num1(balu_num1), .balu_num2(balu_num2),
    .balu_mode(balu_mode), .balu_ans(balu_ans), .balu_error(balu_error), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_illegal(out_illegal));

  always #5 clk = ~clk;

  function automatic logic [31:0] f_clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 32'(31 - i);
    return 32;
  endfunction
  function automatic logic [31:0] f_ctz(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return 32'(i);
    return 32;
  endfunction

  always_comb begin
    balu_ans = 32'h0;
    model_err = 1'b0;
    case (balu_mode)
      8'h30: balu_ans = balu_num1 & ~(32'h1 << balu_num2[4:0]);
      8'h31: balu_ans = (balu_num1 >> balu_num2[4:0]) & 32'h1;
      8'h32: balu_ans = balu_num1 ^ (32'h1 << balu_num2[4:0]);
      8'h33: balu_ans = balu_num1 | (32'h1 << balu_num2[4:0]);
      8'h34: balu_ans = f_clz(balu_num1);
      8'h36: balu_ans = f_ctz(balu_num1);
      8'h37: balu_ans = (balu_num1 << balu_num2[4:0]) | (balu_num1 >> (6'd32 - {1'b0, balu_num2[4:0]}));
      8'h38: balu_ans = (balu_num1 >> balu_num2[4:0]) | (balu_num1 << (6'd32 - {1'b0, balu_num2[4:0]}));
      default: model_err = 1'b1;
    endcase
  end
  assign balu_error = model_err | force_err;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] s, input logic [2:0] f3, input logic [6:0] op);
    return {f7, s, 5'd1, f3, 5'd2, op};
  endfunction

  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; rs1_data = a; rs2_data = b; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0 || out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/0", out_data, out_illegal); end
    checks++; if (balu_mode !== 8'h00 || balu_num1 !== 32'h0 || balu_num2 !== 32'h0) begin failures++; $display("FAIL reset_balu got=%h/%h/%h exp=0", balu_mode, balu_num1, balu_num2); end
    rst = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_bset;
    int lat;
    send(enc(7'b0010100, 5'd2, 3'b001, OP), 32'h0, 32'h25);
    wait_valid(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bset_latency got=%0d exp=2", lat); end
    checks++; if (balu_mode !== 8'h33) begin failures++; $display("FAIL bset_mode got=%h exp=33", balu_mode); end
    checks++; if (out_data !== 32'h20 || out_illegal !== 1'b0) begin failures++; $display("FAIL bset_data got=%h/%b exp=00000020/0", out_data, out_illegal); end
    drain;
  endtask

  task automatic test_rori;
    int lat;
    send(enc(7'b0110000, 5'd4, 3'b101, IMM), 32'h12345678, 32'hFFFFFFFF);
    wait_valid(lat);
    checks++; if (balu_mode !== 8'h38 || balu_num2 !== 32'h4) begin failures++; $display("FAIL rori_decode got=%h/%h exp=38/00000004", balu_mode, balu_num2); end
    checks++; if (out_data !== 32'h81234567 || lat !== 2) begin failures++; $display("FAIL rori_data got=%h lat=%0d exp=81234567 lat=2", out_data, lat); end
    drain;
  endtask

  task automatic test_unary;
    int lat;
    send(enc(7'b0110000, 5'd0, 3'b001, IMM), 32'h00010000, 32'h0);
    wait_valid(lat);
    checks++; if (balu_mode !== 8'h34 || out_data !== 32'd15) begin failures++; $display("FAIL clz got=%h/%0d exp=34/15", balu_mode, out_data); end
    drain;
    send(enc(7'b0110000, 5'd1, 3'b001, IMM), 32'h00010000, 32'h0);
    wait_valid(lat);
    checks++; if (balu_mode !== 8'h36 || out_data !== 32'd16) begin failures++; $display("FAIL ctz got=%h/%0d exp=36/16", balu_mode, out_data); end
    drain;
  endtask

  task automatic test_illegal;
    int lat;
    send(32'h00B50533, 32'h1, 32'h2);
    wait_valid(lat);
    checks++; if (out_illegal !== 1'b1 || out_data !== 32'h0 || lat !== 1) begin failures++; $display("FAIL add_illegal got=%b/%h lat=%0d exp=1/0 lat=1", out_illegal, out_data, lat); end
    checks++; if (balu_mode !== 8'h36 || balu_num1 !== 32'h00010000) begin failures++; $display("FAIL add_balu_held got=%h/%h exp=36/00010000", balu_mode, balu_num1); end
    drain;
    send(enc(7'b0110000, 5'd3, 3'b001, IMM), 32'h1, 32'h0);
    wait_valid(lat);
    checks++; if (out_illegal !== 1'b1 || lat !== 1) begin failures++; $display("FAIL unary3_illegal got=%b lat=%0d exp=1 lat=1", out_illegal, lat); end
    drain;
  endtask

  task automatic test_error;
    int lat;
    force_err = 1;
    send(enc(7'b0010100, 5'd0, 3'b001, OP), 32'h0, 32'h1);
    wait_valid(lat);
    force_err = 0;
    checks++; if (out_illegal !== 1'b1 || out_data !== 32'h2) begin failures++; $display("FAIL balu_error got=%b/%h exp=1/00000002", out_illegal, out_data); end
    drain;
  endtask

  task automatic test_cpop;
    int lat;
    send(enc(7'b0110000, 5'd2, 3'b001, IMM), 32'hF0F00001, 32'h0);
    wait_valid(lat);
`ifdef BALU_CTRL_CPOP_EN
    checks++; if (out_data !== 32'd9 || out_illegal !== 1'b0 || lat !== 9) begin failures++; $display("FAIL cpop got=%0d/%b lat=%0d exp=9/0 lat=9", out_data, out_illegal, lat); end
`else
    checks++; if (out_data !== 32'd0 || out_illegal !== 1'b1 || lat !== 1) begin failures++; $display("FAIL cpop_off got=%0d/%b lat=%0d exp=0/1 lat=1", out_data, out_illegal, lat); end
`endif
    drain;
  endtask

  task automatic test_backpressure;
    int lat;
    send(enc(7'b0100100, 5'd0, 3'b001, OP), 32'hFFFFFFFF, 32'h0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFE || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/fffffffe/0", i, out_valid, out_data, in_ready); end
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back;
    int acc_t[$];
    @(negedge clk);
    instr = enc(7'b0110100, 5'd0, 3'b001, OP); rs1_data = 32'h0; rs2_data = 32'h3;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) acc_t.push_back(i);
      if (out_valid) begin
        checks++; if (out_data !== 32'h8 || out_illegal !== 1'b0) begin failures++; $display("FAIL b2b_data got=%h/%b exp=00000008/0", out_data, out_illegal); end
      end
      @(negedge clk);
    end
    in_valid = 0;
    repeat (4) @(negedge clk);
    out_ready = 0;
    checks++; if (acc_t.size() < 2 || acc_t[1] - acc_t[0] != 3) begin failures++; $display("FAIL b2b_interval got=%0d accepts exp interval=3", acc_t.size()); end
  endtask

  task automatic test_reset_mid;
    int lat;
    send(enc(7'b0110000, 5'd2, 3'b001, IMM), 32'hFFFFFFFF, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL mid_reset got=%b/%h exp=0/0", out_valid, out_data); end
    rst = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
    send(enc(7'b0100100, 5'd0, 3'b101, OP), 32'h80000000, 32'd31);
    wait_valid(lat);
    checks++; if (balu_mode !== 8'h31 || out_data !== 32'h1 || lat !== 2) begin failures++; $display("FAIL bext_after_reset got=%h/%h lat=%0d exp=31/00000001 lat=2", balu_mode, out_data, lat); end
    drain;
  endtask

  initial begin
    test_reset;
    test_bset;
    test_rori;
    test_unary;
    test_illegal;
    test_error;
    test_cpop;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
